// File: rtl/reg_bank_rw.sv
// General-purpose MIPS register bank: 31 stored registers, $0 reads zero,
// two registered read ports. Define REG_BANK_BYPASS_EN for write-first collisions.
module reg_bank_rw #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'd227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [15:0]       writeCount
);

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd1_s;
  logic [DATA_W-1:0] rd2_q, rd2_d, rd2_s;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              we_s;
  logic              hit1_s, hit2_s;

  // Writes to index 0 have no storage to land in, so they are dropped here.
  assign we_s   = RegWrite && (WriteReg != 5'd0);
  assign hit1_s = we_s && (WriteReg == ReadReg1);
  assign hit2_s = we_s && (WriteReg == ReadReg2);

  // Next-state for the register array and the write counter.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = (we_s && (WriteReg == 5'(i))) ? WriteData : regs_q[i];
    end
    if (we_s) begin
      wcnt_d = wcnt_q + 16'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Read muxes; index 0 falls through the loop and yields zero.
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    for (int i = 1; i < 32; i++) begin
      rd1_s = (ReadReg1 == 5'(i)) ? regs_q[i] : rd1_s;
      rd2_s = (ReadReg2 == 5'(i)) ? regs_q[i] : rd2_s;
    end
    if (BYPASS && hit1_s) begin
      rd1_d = WriteData;
    end else begin
      rd1_d = rd1_s;
    end
    if (BYPASS && hit2_s) begin
      rd2_d = WriteData;
    end else begin
      rd2_d = rd2_s;
    end
  end

  // State registers; reset restores sp and clears everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? SP_RESET : '0;
      end
      rd1_q  <= '0;
      rd2_q  <= '0;
      wcnt_q <= 16'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign ReadData1  = rd1_q;
  assign ReadData2  = rd2_q;
  assign writeCount = wcnt_q;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed self-checking bench for reg_bank_rw; collision expectation follows
// REG_BANK_BYPASS_EN.
module tb_reg_bank_rw;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [15:0]       writeCount;

  int n_vec;
  int n_err;
  logic [DATA_W-1:0] last_val;
  logic [DATA_W-1:0] coll_exp;

  reg_bank_rw #(.DATA_W(DATA_W), .SP_RESET(32'd227)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .writeCount(writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
    ReadReg1 = 5'd29; ReadReg2 = 5'd31;
    #1 reset = 1'b1;
    tick(); tick();
    check_eq("rst_rd1", ReadData1, 32'd0);
    check_eq("rst_wc", {16'd0, writeCount}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("sp_reset", ReadData1, 32'd227);
    check_eq("ra_reset", ReadData2, 32'd0);
    check_eq("wc_reset", {16'd0, writeCount}, 32'd0);

    // write reg 8, read it back
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd8;
    tick();
    check_eq("rd_r8", ReadData1, 32'hDEADBEEF);
    check_eq("wc_1", {16'd0, writeCount}, 32'd1);

    // write to $0 is discarded, reads of 0 stay 0
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    tick();
    check_eq("r0_coll_p1", ReadData1, 32'd0);
    check_eq("r0_coll_p2", ReadData2, 32'd0);
    RegWrite = 1'b0;
    tick();
    check_eq("r0_p1", ReadData1, 32'd0);
    check_eq("r0_p2", ReadData2, 32'd0);
    check_eq("wc_r0", {16'd0, writeCount}, 32'd1);

    // collision on port 2
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h11;
    tick();
`ifdef REG_BANK_BYPASS_EN
    coll_exp = 32'h22;
`else
    coll_exp = 32'h11;
`endif
    WriteData = 32'h22; ReadReg2 = 5'd5; ReadReg1 = 5'd8;
    tick();
    check_eq("coll_p2", ReadData2, coll_exp);
    check_eq("coll_p1_other", ReadData1, 32'hDEADBEEF);
    check_eq("wc_coll", {16'd0, writeCount}, 32'd3);
    RegWrite = 1'b0; ReadReg1 = 5'd5;
    tick();
    check_eq("after_coll_p2", ReadData2, 32'h22);
    check_eq("same_reg_p1", ReadData1, 32'h22);

    // jal path then asynchronous reset mid-cycle
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h400;
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd8;
    tick();
    check_eq("ra_write", ReadData1, 32'h400);
    check_eq("r8_keep", ReadData2, 32'hDEADBEEF);
    check_eq("wc_4", {16'd0, writeCount}, 32'd4);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rd1", ReadData1, 32'd0);
    check_eq("async_rd2", ReadData2, 32'd0);
    check_eq("async_wc", {16'd0, writeCount}, 32'd0);
    // a write presented during reset must not land
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hAAAA5555;
    tick();
    check_eq("rst_hold_rd1", ReadData1, 32'd0);
    reset = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd29;
    tick();
    check_eq("ra_after_rst", ReadData1, 32'd0);
    check_eq("sp_after_rst", ReadData2, 32'd227);
    ReadReg1 = 5'd8; ReadReg2 = 5'd3;
    tick();
    check_eq("r8_after_rst", ReadData1, 32'd0);
    check_eq("r3_no_write", ReadData2, 32'd0);
    check_eq("wc_after_rst", {16'd0, writeCount}, 32'd0);

    // 65536 writes to reg 1: counter wraps to 0
    RegWrite = 1'b1; WriteReg = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      WriteData = 32'(i) * 32'd3 + 32'd7;
      tick();
      if (i == 65534) check_eq("wc_ffff", {16'd0, writeCount}, 32'h0000FFFF);
    end
    last_val = 32'd65535 * 32'd3 + 32'd7;
    check_eq("wc_wrap", {16'd0, writeCount}, 32'd0);
    RegWrite = 1'b0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd1;
    tick();
    check_eq("r1_last", ReadData1, last_val);
    tick();
    check_eq("r1_no_we", ReadData1, last_val);
    check_eq("wc_no_we", {16'd0, writeCount}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
